bin_load_ctrl: RTL and testbench

Sequencer between the PowerPC-written `load_bins` software register and the channelizer's double-buffered bin-select table. It decodes a 32-bit command word, then issues single, range-fill or clear writes to the table's shadow bank over a valid/ready port. A commit command swaps banks on the next frame sync pulse. Runs entirely in the `user_clk` domain, downstream of the OPB-to-Simulink register.

---
 rtl/bin_load_pkg.sv | 38 +++
 rtl/bin_load_edge.sv | 38 +++
 rtl/bin_load_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_bin_load_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_load_pkg.sv
// bin_load_pkg
// Shared definitions for the bin-select table load sequencer:
//   - opcode_e : command opcodes carried in load_reg[30:29]
//   - state_e  : sequencer FSM states
//   - bit positions and widths of the command-word fields
//   - bit positions of the status word
package bin_load_pkg;

  typedef enum logic [1:0] {
    OP_SINGLE = 2'b00,
    OP_FILL   = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_COMMIT = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WRITE     = 2'b01,
    ST_WAIT_SYNC = 2'b10
  } state_e;

  // Command word layout
  localparam int ARM_BIT      = 31;
  localparam int OP_LO        = 29;
  localparam int OP_W         = 2;
  localparam int ADDR_LO      = 20;
  localparam int ADDR_FIELD_W = 9;
  localparam int CNT_LO       = 12;
  localparam int CNT_FIELD_W  = 8;
  localparam int BIN_LO       = 0;
  localparam int BIN_FIELD_W  = 12;

  // Status word layout
  localparam int STAT_BUSY    = 31;
  localparam int STAT_ERR     = 30;
  localparam int STAT_CNT_W   = 16;

endpackage

// File: rtl/bin_load_edge.sv
// bin_load_edge
// Registers the quasi-static software command word and detects a rising
// edge of its arm bit.
// Ports:
//   clk      in   clock
//   srst     in   synchronous active-high reset
//   load_reg in   32-bit command word from the software register
//   cmd_q    out  registered command fields (bits 30:0)
//   arm_edge out  high for one cycle after the registered arm bit rises
module bin_load_edge
  import bin_load_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic [31:0] load_reg,
  output logic [30:0] cmd_q,
  output logic        arm_edge
);

  logic [31:0] load_q_reg;
  logic        arm_prev_reg;

  // The command register keeps sampling during reset while the arm history
  // is forced to 1. An arm bit that is already high when reset releases
  // therefore matches the history and produces no edge.
  always_ff @(posedge clk) begin
    load_q_reg <= load_reg;
    if (srst) begin
      arm_prev_reg <= 1'b1;
    end else begin
      arm_prev_reg <= load_q_reg[ARM_BIT];
    end
  end

  assign arm_edge = load_q_reg[ARM_BIT] & ~arm_prev_reg;
  assign cmd_q    = load_q_reg[30:0];

endmodule

// File: rtl/bin_load_ctrl.sv
// bin_load_ctrl
// Decodes the load_bins command word and writes the shadow bank of the
// double-buffered bin-select table (single / range-fill / clear), or
// requests a bank swap on the next frame sync.
// Ports:
//   user_clk  in   clock
//   user_rst  in   synchronous active-high reset
//   load_reg  in   32-bit command word (arm, opcode, addr, count-1, bin)
//   sync_in   in   one-cycle frame-boundary pulse
//   tbl_we    out  write valid to the shadow bank
//   tbl_ready in   table accepts a write this cycle
//   tbl_addr  out  write address
//   tbl_data  out  bin index to write
//   tbl_swap  out  one-cycle bank-swap pulse
//   status    out  [31] busy, [30] sticky error, [15:0] completed commands
module bin_load_ctrl
  import bin_load_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int BIN_W  = 12
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       load_reg,
  input  logic              sync_in,
  output logic              tbl_we,
  input  logic              tbl_ready,
  output logic [ADDR_W-1:0] tbl_addr,
  output logic [BIN_W-1:0]  tbl_data,
  output logic              tbl_swap,
  output logic [31:0]       status
);

  // Remaining-writes counter must hold both count-1 of a FILL and
  // 2^ADDR_W-1 of a CLEAR.
  localparam int CNT_W = (ADDR_W > CNT_FIELD_W) ? ADDR_W : CNT_FIELD_W;
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'((1 << ADDR_W) - 1);

  logic [30:0] cmd_q;
  logic        arm_edge;

  bin_load_edge u_edge (
    .clk      (user_clk),
    .srst     (user_rst),
    .load_reg (load_reg),
    .cmd_q    (cmd_q),
    .arm_edge (arm_edge)
  );

  // Command field decode
  opcode_e                 op;
  logic [ADDR_W-1:0]       addr_field;
  logic [CNT_FIELD_W-1:0]  cnt_field;
  logic [BIN_FIELD_W-1:0]  bin_field;
  logic                    bin_ovf;

  assign op         = opcode_e'(cmd_q[OP_LO +: OP_W]);
  assign addr_field = cmd_q[ADDR_LO +: ADDR_W];
  assign cnt_field  = cmd_q[CNT_LO +: CNT_FIELD_W];
  assign bin_field  = cmd_q[BIN_LO +: BIN_FIELD_W];
  // Any set bit above the table's bin width means the value gets truncated.
  assign bin_ovf    = (({20'd0, bin_field} >> BIN_W) != 32'd0);

  state_e            state_reg, state_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [BIN_W-1:0]  data_reg, data_next;
  logic [CNT_W-1:0]  remain_reg, remain_next;
  logic              swap_reg, swap_next;
  logic              err_reg, err_next;
  logic              busy_reg, busy_next;
  logic [STAT_CNT_W-1:0] done_reg, done_next;

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_reg  <= ST_IDLE;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      data_reg   <= '0;
      remain_reg <= '0;
      swap_reg   <= 1'b0;
      err_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      remain_reg <= remain_next;
      swap_reg   <= swap_next;
      err_reg    <= err_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    we_next     = we_reg;
    addr_next   = addr_reg;
    data_next   = data_reg;
    remain_next = remain_reg;
    swap_next   = 1'b0;
    err_next    = err_reg;
    done_next   = done_reg;

    // A new command while one is in flight is dropped; this includes the
    // cycle in which the FSM is about to return to IDLE.
    if (arm_edge && (state_reg != ST_IDLE)) begin
      err_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (arm_edge) begin
          if (bin_ovf) begin
            err_next = 1'b1;
          end
          case (op)
            OP_SINGLE: begin
              addr_next   = addr_field;
              data_next   = bin_field[BIN_W-1:0];
              remain_next = '0;
              we_next     = 1'b1;
              state_next  = ST_WRITE;
            end
            OP_FILL: begin
              addr_next   = addr_field;
              data_next   = bin_field[BIN_W-1:0];
              remain_next = CNT_W'(cnt_field);
              we_next     = 1'b1;
              state_next  = ST_WRITE;
            end
            OP_CLEAR: begin
              addr_next   = '0;
              data_next   = '0;
              remain_next = CLEAR_LAST;
              we_next     = 1'b1;
              state_next  = ST_WRITE;
            end
            default: begin
              state_next = ST_WAIT_SYNC;
            end
          endcase
        end
      end

      ST_WRITE: begin
        // remain_reg counts the writes left after the one being presented.
        if (we_reg && tbl_ready) begin
          if (remain_reg == '0) begin
            we_next    = 1'b0;
            state_next = ST_IDLE;
            done_next  = done_reg + 16'd1;
          end else begin
            addr_next   = addr_reg + ADDR_W'(1);
            remain_next = remain_reg - CNT_W'(1);
          end
        end
      end

      ST_WAIT_SYNC: begin
        if (sync_in) begin
          swap_next  = 1'b1;
          state_next = ST_IDLE;
          done_next  = done_reg + 16'd1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        we_next    = 1'b0;
      end
    endcase
  end

  // busy is registered from the next state so it tracks state_reg exactly.
  assign busy_next = (state_next != ST_IDLE);

  assign tbl_we   = we_reg;
  assign tbl_addr = addr_reg;
  assign tbl_data = data_reg;
  assign tbl_swap = swap_reg;

  always_comb begin
    status                   = '0;
    status[STAT_BUSY]        = busy_reg;
    status[STAT_ERR]         = err_reg;
    status[STAT_CNT_W-1:0]   = done_reg;
  end

endmodule

// File: tb/tb_bin_load_ctrl.sv
// tb_bin_load_ctrl
// Self-checking bench for bin_load_ctrl: a cycle table for SINGLE and FILL,
// then hand-written sequences for COMMIT, stalled CLEAR, overlapping arm,
// and reset in the middle of a CLEAR.
module tb_bin_load_ctrl;

  logic        user_clk;
  logic        user_rst;
  logic [31:0] load_reg;
  logic        sync_in;
  logic        tbl_we;
  logic        tbl_ready;
  logic [8:0]  tbl_addr;
  logic [11:0] tbl_data;
  logic        tbl_swap;
  logic [31:0] status;

  int n_checks = 0;
  int n_fail   = 0;

  bin_load_ctrl #(.ADDR_W(9), .BIN_W(12)) dut (
    .user_clk  (user_clk),
    .user_rst  (user_rst),
    .load_reg  (load_reg),
    .sync_in   (sync_in),
    .tbl_we    (tbl_we),
    .tbl_ready (tbl_ready),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .tbl_swap  (tbl_swap),
    .status    (status)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  // Command words
  localparam logic [31:0] W_SINGLE = 32'h805001A3; // addr 0x005, bin 0x1A3
  localparam logic [31:0] W_FILL   = 32'hBFE03010; // addr 0x1FE, count-1 3, bin 0x010
  localparam logic [31:0] W_FILL2  = 32'hA1003055; // addr 0x010, count-1 3, bin 0x055
  localparam logic [31:0] W_CLEAR  = 32'hC0000000;
  localparam logic [31:0] W_COMMIT = 32'hE0000000;

  typedef struct {
    logic [31:0] load;
    logic        ready;
    logic        exp_we;
    logic [8:0]  exp_addr;
    logic [11:0] exp_data;
    logic [31:0] exp_status;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs an in-progress write sequence to completion, checking each
  // accepted write and that outputs hold while ready is low.
  task automatic collect(input string name, input logic [8:0] start_addr,
                         input logic [11:0] exp_data, input int exp_n,
                         input bit toggle, input int budget);
    int          acc;
    int          cyc;
    logic [8:0]  ea;
    logic [8:0]  held_addr;
    logic [11:0] held_data;
    bit          stalled;
    logic        rdy;
    acc = 0;
    cyc = 0;
    ea = start_addr;
    stalled = 1'b0;
    held_addr = '0;
    held_data = '0;
    while (status[31] && (cyc < budget)) begin
      rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
      tbl_ready = rdy;
      if (stalled) begin
        check({name, "_hold_addr"}, 32'(tbl_addr), 32'(held_addr));
        check({name, "_hold_data"}, 32'(tbl_data), 32'(held_data));
      end
      stalled = 1'b0;
      if (tbl_we) begin
        if (rdy) begin
          check({name, "_addr"}, 32'(tbl_addr), 32'(ea));
          check({name, "_data"}, 32'(tbl_data), 32'(exp_data));
          ea = ea + 9'd1;
          acc++;
        end else begin
          stalled = 1'b1;
          held_addr = tbl_addr;
          held_data = tbl_data;
        end
      end
      tick();
      cyc++;
    end
    check({name, "_nwrites"}, 32'(acc), 32'(exp_n));
    check({name, "_busy_done"}, 32'(status[31]), 32'd0);
    check({name, "_we_done"}, 32'(tbl_we), 32'd0);
  endtask

  initial begin
    user_rst  = 1'b1;
    load_reg  = 32'h0;
    sync_in   = 1'b0;
    tbl_ready = 1'b0;

    //                 load      rdy   we    addr     data      status
    vecs[0]  = '{W_SINGLE, 1'b1, 1'b0, 9'h000, 12'h000, 32'h0000_0000};
    vecs[1]  = '{W_SINGLE, 1'b1, 1'b1, 9'h005, 12'h1A3, 32'h8000_0000};
    vecs[2]  = '{W_SINGLE, 1'b1, 1'b0, 9'h000, 12'h000, 32'h0000_0001};
    vecs[3]  = '{32'h0,    1'b1, 1'b0, 9'h000, 12'h000, 32'h0000_0001};
    vecs[4]  = '{32'h0,    1'b1, 1'b0, 9'h000, 12'h000, 32'h0000_0001};
    vecs[5]  = '{W_FILL,   1'b1, 1'b0, 9'h000, 12'h000, 32'h0000_0001};
    vecs[6]  = '{W_FILL,   1'b1, 1'b1, 9'h1FE, 12'h010, 32'h8000_0001};
    vecs[7]  = '{W_FILL,   1'b1, 1'b1, 9'h1FF, 12'h010, 32'h8000_0001};
    vecs[8]  = '{W_FILL,   1'b1, 1'b1, 9'h000, 12'h010, 32'h8000_0001};
    vecs[9]  = '{W_FILL,   1'b1, 1'b1, 9'h001, 12'h010, 32'h8000_0001};
    vecs[10] = '{W_FILL,   1'b1, 1'b0, 9'h000, 12'h000, 32'h0000_0002};
    vecs[11] = '{32'h0,    1'b1, 1'b0, 9'h000, 12'h000, 32'h0000_0002};
    vecs[12] = '{32'h0,    1'b1, 1'b0, 9'h000, 12'h000, 32'h0000_0002};

    // Reset state
    tick(); tick(); tick();
    check("rst_we", 32'(tbl_we), 32'd0);
    check("rst_swap", 32'(tbl_swap), 32'd0);
    check("rst_addr", 32'(tbl_addr), 32'd0);
    check("rst_data", 32'(tbl_data), 32'd0);
    check("rst_status", status, 32'd0);
    user_rst = 1'b0;
    tick();

    // SINGLE and FILL, cycle by cycle
    for (int i = 0; i < 13; i++) begin
      load_reg  = vecs[i].load;
      tbl_ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d_we", i), 32'(tbl_we), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d_status", i), status, vecs[i].exp_status);
      check($sformatf("vec%0d_swap", i), 32'(tbl_swap), 32'd0);
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d_addr", i), 32'(tbl_addr), 32'(vecs[i].exp_addr));
        check($sformatf("vec%0d_data", i), 32'(tbl_data), 32'(vecs[i].exp_data));
      end
      $display("vec %0d: load=%h we=%0b addr=%h data=%h status=%h",
               i, vecs[i].load, tbl_we, tbl_addr, tbl_data, status);
    end

    // COMMIT: sync on the arm-edge cycle is ignored, a later one swaps
    load_reg = W_COMMIT;
    tick();                 // load_q captured, arm edge visible this cycle
    sync_in = 1'b1;         // coincides with the arm edge
    tick();
    sync_in = 1'b0;
    check("commit_busy", 32'(status[31]), 32'd1);
    check("commit_early_swap", 32'(tbl_swap), 32'd0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("commit_wait_swap", 32'(tbl_swap), 32'd0);
      check("commit_wait_busy", 32'(status[31]), 32'd1);
    end
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    check("commit_swap", 32'(tbl_swap), 32'd1);
    check("commit_status", status, 32'h0000_0003);
    tick();
    check("commit_swap_pulse", 32'(tbl_swap), 32'd0);
    sync_in = 1'b1;         // idle sync must not swap
    tick();
    sync_in = 1'b0;
    check("idle_sync_swap", 32'(tbl_swap), 32'd0);
    $display("commit: status=%h", status);

    // CLEAR with ready toggling
    load_reg = 32'h0;
    tick(); tick();
    load_reg = W_CLEAR;
    tbl_ready = 1'b0;
    tick(); tick();
    check("clear_start_we", 32'(tbl_we), 32'd1);
    collect("clear", 9'h000, 12'h000, 512, 1'b1, 2000);
    check("clear_status", status, 32'h0000_0004);
    $display("clear: status=%h", status);

    // Second arm edge during a stalled FILL
    load_reg = 32'h0;
    tick(); tick();
    load_reg = W_FILL2;
    tbl_ready = 1'b0;
    tick(); tick();
    check("ovl_busy", 32'(status[31]), 32'd1);
    check("ovl_addr0", 32'(tbl_addr), 32'h010);
    load_reg = 32'h0;
    tick(); tick();
    load_reg = W_SINGLE;
    tick(); tick();
    check("ovl_err", 32'(status[30]), 32'd1);
    check("ovl_stall_addr", 32'(tbl_addr), 32'h010);
    collect("ovl_fill", 9'h010, 12'h055, 4, 1'b0, 50);
    tick(); tick();
    check("ovl_no_extra_we", 32'(tbl_we), 32'd0);
    check("ovl_status", status, 32'h4000_0005);
    $display("overlap: status=%h", status);

    // Reset during CLEAR with arm held high through reset
    load_reg = 32'h0;
    tick(); tick();
    load_reg = W_CLEAR;
    tick(); tick();
    tbl_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("midclr_we", 32'(tbl_we), 32'd1);
    check("midclr_addr", 32'(tbl_addr), 32'd20);
    user_rst = 1'b1;
    tick();
    check("midrst_we", 32'(tbl_we), 32'd0);
    check("midrst_status", status, 32'd0);
    check("midrst_addr", 32'(tbl_addr), 32'd0);
    tick();
    user_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("postrst_we", 32'(tbl_we), 32'd0);
      check("postrst_status", status, 32'd0);
    end
    $display("reset: we=%0b status=%h", tbl_we, status);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
